// File: rtl/riscv_structures.sv
// Shared RV32I pipeline types: decoded control word, bubble constant, widths.
package riscv_structures;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_IDX_W    = 5;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       is_load;
    logic       is_store;
    logic       reg_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL_DEFAULT = ctrl_t'(0);

  // True when a write-back to reg idx is architecturally visible (x0 never is).
  function automatic logic wb_hits(input logic [REG_IDX_W-1:0] idx,
                                   input logic [REG_IDX_W-1:0] wb_a3,
                                   input logic                 wb_we3);
    return wb_we3 && (wb_a3 != REG_IDX_W'(0)) && (wb_a3 == idx);
  endfunction

endpackage

// File: rtl/rf_bypass.sv
// Write-back bypass mux for one source operand; hit flags a same-cycle write to rs.
module rf_bypass
  import riscv_structures::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [XLEN-1:0]      rf_d,
  input  logic [REG_IDX_W-1:0] wb_a3,
  input  logic                 wb_we3,
  input  logic [XLEN-1:0]      wb_wd,
  output logic [XLEN-1:0]      val,
  output logic                 hit
);

  always_comb begin
    hit = wb_hits(rs, wb_a3, wb_we3);
    val = hit ? wb_wd : rf_d;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with write-back bypass, held-operand
// refresh and load-use stall. Define ID_EX_WB_BYPASS_EN to enable the bypass.
module id_ex_stage
  import riscv_structures::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter ctrl_t       NOP_CTRL = ctrl_t'(0)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic [XLEN-1:0]      in_imm,
  input  ctrl_t                in_ctrl,
  input  logic                 stall,
  input  logic                 flush,
  output logic [REG_IDX_W-1:0] rf_a1,
  output logic [REG_IDX_W-1:0] rf_a2,
  input  logic [XLEN-1:0]      rf_d1,
  input  logic [XLEN-1:0]      rf_d2,
  input  logic [REG_IDX_W-1:0] wb_a3,
  input  logic                 wb_we3,
  input  logic [XLEN-1:0]      wb_wd,
  output logic                 hazard_stall,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_imm,
  output logic [XLEN-1:0]      ex_rs1_val,
  output logic [XLEN-1:0]      ex_rs2_val,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output ctrl_t                ex_ctrl
);

  logic                 ex_valid_q,   ex_valid_d;
  logic [XLEN-1:0]      ex_pc_q,      ex_pc_d;
  logic [XLEN-1:0]      ex_imm_q,     ex_imm_d;
  logic [XLEN-1:0]      ex_rs1_val_q, ex_rs1_val_d;
  logic [XLEN-1:0]      ex_rs2_val_q, ex_rs2_val_d;
  logic [REG_IDX_W-1:0] ex_rs1_q,     ex_rs1_d;
  logic [REG_IDX_W-1:0] ex_rs2_q,     ex_rs2_d;
  logic [REG_IDX_W-1:0] ex_rd_q,      ex_rd_d;
  ctrl_t                ex_ctrl_q,    ex_ctrl_d;

  logic                 byp_we_c;
  logic [XLEN-1:0]      cap1_val_c, cap2_val_c, hold1_val_c, hold2_val_c;
  logic                 cap1_hit_c, cap2_hit_c, hold1_hit_c, hold2_hit_c;

`ifdef ID_EX_WB_BYPASS_EN
  assign byp_we_c = wb_we3;
`else
  // With the bypass compiled out no snooped write ever matches.
  logic unused_wb_we3;
  assign unused_wb_we3 = wb_we3;
  assign byp_we_c      = 1'b0;
`endif

  assign rf_a1 = in_rs1;
  assign rf_a2 = in_rs2;

  rf_bypass #(.XLEN(XLEN)) u_cap1 (
    .rs(in_rs1), .rf_d(rf_d1), .wb_a3(wb_a3), .wb_we3(byp_we_c), .wb_wd(wb_wd),
    .val(cap1_val_c), .hit(cap1_hit_c)
  );
  rf_bypass #(.XLEN(XLEN)) u_cap2 (
    .rs(in_rs2), .rf_d(rf_d2), .wb_a3(wb_a3), .wb_we3(byp_we_c), .wb_wd(wb_wd),
    .val(cap2_val_c), .hit(cap2_hit_c)
  );
  rf_bypass #(.XLEN(XLEN)) u_hold1 (
    .rs(ex_rs1_q), .rf_d(ex_rs1_val_q), .wb_a3(wb_a3), .wb_we3(byp_we_c), .wb_wd(wb_wd),
    .val(hold1_val_c), .hit(hold1_hit_c)
  );
  rf_bypass #(.XLEN(XLEN)) u_hold2 (
    .rs(ex_rs2_q), .rf_d(ex_rs2_val_q), .wb_a3(wb_a3), .wb_we3(byp_we_c), .wb_wd(wb_wd),
    .val(hold2_val_c), .hit(hold2_hit_c)
  );

  // Capture-side hit flags are informational; the mux already applied them.
  logic unused_cap_hits;
  assign unused_cap_hits = cap1_hit_c ^ cap2_hit_c;

  assign hazard_stall = in_valid && ex_valid_q && ex_ctrl_q.is_load &&
                        (ex_rd_q != REG_IDX_W'(0)) &&
                        ((ex_rd_q == in_rs1) || (ex_rd_q == in_rs2));

  // Priority: flush > stall (with held refresh) > load-use bubble > capture.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_imm_d     = ex_imm_q;
    ex_rs1_val_d = ex_rs1_val_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_rd_d      = ex_rd_q;
    ex_ctrl_d    = ex_ctrl_q;

    if (flush) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = NOP_CTRL;
    end else if (stall) begin
      if (ex_valid_q && hold1_hit_c) ex_rs1_val_d = hold1_val_c;
      if (ex_valid_q && hold2_hit_c) ex_rs2_val_d = hold2_val_c;
    end else if (hazard_stall) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = NOP_CTRL;
    end else begin
      ex_valid_d   = in_valid;
      ex_pc_d      = in_pc;
      ex_imm_d     = in_imm;
      ex_rs1_val_d = cap1_val_c;
      ex_rs2_val_d = cap2_val_c;
      ex_rs1_d     = in_rs1;
      ex_rs2_d     = in_rs2;
      ex_rd_d      = in_rd;
      // Keep the invariant that an invalid slot always carries the bubble word.
      ex_ctrl_d    = in_valid ? in_ctrl : NOP_CTRL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_imm_q     <= '0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      ex_ctrl_q    <= NOP_CTRL;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs1_val_q <= ex_rs1_val_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_rd_q      <= ex_rd_d;
      ex_ctrl_q    <= ex_ctrl_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs1_val = ex_rs1_val_q;
  assign ex_rs2_val = ex_rs2_val_q;
  assign ex_rs1     = ex_rs1_q;
  assign ex_rs2     = ex_rs2_q;
  assign ex_rd      = ex_rd_q;
  assign ex_ctrl    = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow ID_EX_WB_BYPASS_EN.
module tb_id_ex_stage;
  import riscv_structures::*;

  logic        clk, rst_n;
  logic        in_valid;
  logic [31:0] in_pc, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  ctrl_t       in_ctrl;
  logic        stall, flush;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_d1, rf_d2;
  logic [4:0]  wb_a3;
  logic        wb_we3;
  logic [31:0] wb_wd;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  ctrl_t       ex_ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  ctrl_t alu_c, lw_c;
  logic  byp;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_d1(rf_d1), .rf_d2(rf_d2), .wb_a3(wb_a3), .wb_we3(wb_we3), .wb_wd(wb_wd),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ID_EX_WB_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    alu_c = ctrl_t'(0); alu_c.alu_op = 4'd3; alu_c.reg_write = 1'b1;
    lw_c  = ctrl_t'(0); lw_c.is_load = 1'b1; lw_c.reg_write = 1'b1; lw_c.alu_src = 1'b1;

    rst_n = 1'b1; in_valid = 1'b0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
    in_rd = '0; in_ctrl = ctrl_t'(0); stall = 1'b0; flush = 1'b0; rf_d1 = '0; rf_d2 = '0;
    wb_a3 = '0; wb_we3 = 1'b0; wb_wd = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_ctrl", 32'(ex_ctrl), 32'd0);
    chk("reset_pc", ex_pc, 32'd0);
    tick();
    rst_n = 1'b1;

    // plain capture
    in_valid = 1'b1; in_pc = 32'h100; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd4;
    in_imm = 32'h10; in_ctrl = alu_c; rf_d1 = 32'hA; rf_d2 = 32'hB;
    #1;
    chk("rf_a1_comb", 32'(rf_a1), 32'd1);
    chk("rf_a2_comb", 32'(rf_a2), 32'd2);
    tick();
    chk("cap_valid", 32'(ex_valid), 32'd1);
    chk("cap_pc", ex_pc, 32'h100);
    chk("cap_rs1_val", ex_rs1_val, 32'hA);
    chk("cap_rs2_val", ex_rs2_val, 32'hB);
    chk("cap_rd", 32'(ex_rd), 32'd4);
    chk("cap_imm", ex_imm, 32'h10);
    chk("cap_ctrl", 32'(ex_ctrl), 32'(alu_c));

    // same-cycle bypass
    in_pc = 32'h104; in_rs1 = 5'd5; rf_d1 = 32'h11;
    wb_we3 = 1'b1; wb_a3 = 5'd5; wb_wd = 32'hDEADBEEF;
    tick();
    chk("byp_rs1_val", ex_rs1_val, byp ? 32'hDEADBEEF : 32'h11);
    chk("byp_rs2_untouched", ex_rs2_val, 32'hB);

    wb_a3 = 5'd0;
    tick();
    chk("byp_x0_addr", ex_rs1_val, 32'h11);
    in_rs1 = 5'd0; rf_d1 = 32'h0;
    tick();
    chk("byp_rs1_x0", ex_rs1_val, 32'h0);
    wb_we3 = 1'b0;

    // asynchronous reset mid-stream
    in_pc = 32'h200; in_rs1 = 5'd6; in_rs2 = 5'd7; in_rd = 5'd8;
    rf_d1 = 32'h66; rf_d2 = 32'h77;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(ex_valid), 32'd0);
    chk("midreset_ctrl", 32'(ex_ctrl), 32'd0);
    chk("midreset_pc", ex_pc, 32'd0);
    tick();
    chk("inreset_valid", 32'(ex_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_valid", 32'(ex_valid), 32'd1);
    chk("post_reset_pc", ex_pc, 32'h200);
    chk("post_reset_rs2_val", ex_rs2_val, 32'h77);

    // stall with held-operand refresh of rs2=x7
    stall = 1'b1; in_pc = 32'h300; rf_d2 = 32'h999;
    tick();
    chk("stall1_rs2_val", ex_rs2_val, 32'h77);
    chk("stall1_pc", ex_pc, 32'h200);
    wb_we3 = 1'b1; wb_a3 = 5'd7; wb_wd = 32'h1234;
    tick();
    wb_we3 = 1'b0;
    chk("stall2_rs2_val", ex_rs2_val, byp ? 32'h1234 : 32'h77);
    chk("stall2_rs1_val", ex_rs1_val, 32'h66);
    chk("stall2_rd", 32'(ex_rd), 32'd8);
    tick();
    chk("stall3_rs2_val", ex_rs2_val, byp ? 32'h1234 : 32'h77);
    chk("stall3_pc", ex_pc, 32'h200);
    stall = 1'b0;

    // load-use: lw x3 then consumer of x3
    in_pc = 32'h400; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3; in_ctrl = lw_c;
    tick();
    chk("lw_valid", 32'(ex_valid), 32'd1);
    chk("lw_ctrl", 32'(ex_ctrl), 32'(lw_c));
    in_pc = 32'h404; in_rs1 = 5'd3; in_rs2 = 5'd0; in_rd = 5'd9; in_ctrl = alu_c;
    #1;
    chk("hazard_raised", 32'(hazard_stall), 32'd1);
    tick();
    chk("bubble_valid", 32'(ex_valid), 32'd0);
    chk("bubble_ctrl", 32'(ex_ctrl), 32'd0);
    chk("hazard_dropped", 32'(hazard_stall), 32'd0);
    tick();
    chk("dep_valid", 32'(ex_valid), 32'd1);
    chk("dep_pc", ex_pc, 32'h404);
    chk("dep_rs1", 32'(ex_rs1), 32'd3);

    // flush beats stall
    flush = 1'b1; stall = 1'b1;
    tick();
    chk("flush_stall_valid", 32'(ex_valid), 32'd0);
    chk("flush_stall_ctrl", 32'(ex_ctrl), 32'd0);
    flush = 1'b0; stall = 1'b0;
    tick();
    chk("recapture_valid", 32'(ex_valid), 32'd1);

    // flush beats refresh
    flush = 1'b1; stall = 1'b1; wb_we3 = 1'b1; wb_a3 = 5'd3; wb_wd = 32'hCAFE;
    tick();
    chk("flush_refresh_valid", 32'(ex_valid), 32'd0);
    chk("flush_refresh_ctrl", 32'(ex_ctrl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the RV32I core. It drives the register file read addresses from the decoded instruction, captures the read data with write-back bypass, and holds the result for the execute stage. It sits directly upstream of execute and is the consumer of the register file read ports. It also snoops the register file write port so captured operands are never stale, and it raises the load-use stall request.

## Interface
Parameters:
- XLEN, 32, data/PC width
- NOP_CTRL, ctrl_t'(0), control word loaded on reset/flush (bubble)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode holds a valid instruction
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_imm  in  XLEN  decoded immediate
- in_ctrl  in  ctrl_t  decoded control word (includes is_load, reg_write)
- stall  in  1  external hold (e.g. memory busy)
- flush  in  1  branch/jump redirect; kill stage contents
- rf_a1, rf_a2  out  5  register file read addresses (combinational = in_rs1/in_rs2)
- rf_d1, rf_d2  in  XLEN  register file read data (x0 already reads 0)
- wb_a3  in  5  register file write address (snooped)
- wb_we3  in  1  register file write enable (snooped)
- wb_wd  in  XLEN  register file write data (snooped)
- hazard_stall  out  1  load-use stall request to fetch/decode
- ex_valid  out  1  execute-stage instruction valid
- ex_pc, ex_imm  out  XLEN  registered PC/immediate
- ex_rs1_val, ex_rs2_val  out  XLEN  registered operands
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices
- ex_ctrl  out  ctrl_t  registered control word

## Operation
- Operand select, per source s: if bypass matches (wb_we3 && wb_a3 != 0 && wb_a3 == in_rs_s), use wb_wd; otherwise use rf_d_s. The register file writes on the same edge, so its read data is stale for that cycle.
- Load-use hazard: hazard_stall = in_valid && ex_valid && ex_ctrl.is_load && ex_rd != 0 && (ex_rd == in_rs1 || ex_rd == in_rs2). The condition is combinational.
- Update priority at each posedge:
  1. flush: ex_valid<=0, ex_ctrl<=NOP_CTRL. Other fields are don't-care and are held.
  2. stall: hold all fields. Held-operand refresh: if a bypass match occurs against ex_rs1/ex_rs2 while ex_valid, the matching ex_rs*_val<=wb_wd.
  3. hazard_stall: insert a bubble (ex_valid<=0, ex_ctrl<=NOP_CTRL). Decode holds its instruction.
  4. Otherwise capture: ex_valid<=in_valid, all in_* fields, and the bypassed operands.
- ex_valid=0 implies ex_ctrl==NOP_CTRL.
- Index 0 never bypasses and never refreshes, so x0 always reads 0.

## Timing
- Reset (async, rst_n=0): ex_valid=0, ex_ctrl=NOP_CTRL, all other ex_* = 0. rf_a1/rf_a2 track in_rs1/in_rs2 and are combinational.
- Latency: one cycle from decode to ex_*.
- hazard_stall is asserted for exactly one cycle per load-use pair. On the next cycle the load has left the stage (ex_valid=0), so hazard_stall drops.
- Simultaneous flush+stall: flush wins.
- Simultaneous stall+write-back to a held rs: the refresh is applied. Simultaneous flush+refresh: flush wins.
- Reset mid-operation: immediate bubble. The first capture happens on the first posedge with rst_n=1.

## Configuration
- ID_EX_WB_BYPASS_EN defined: same-cycle bypass and held-operand refresh are active, as described above.
- ID_EX_WB_BYPASS_EN undefined:
  - Operands are rf_d1/rf_d2 verbatim and there is no refresh.
  - The wb_* ports remain but are unused.
  - Software or scheduling must then guarantee that no read-after-write occurs within one cycle.

## Structure
- riscv_structures package holds:
  - ctrl_t (packed; includes is_load, reg_write)
  - the NOP_CTRL constant
  - the XLEN default
- Sub-module rf_bypass: combinational; takes (rs, rf_d, wb_a3, wb_we3, wb_wd) and returns (val, hit). It has two instances for capture and two for held refresh.

## Test plan
- Reset: rst_n=0 mid-stream -> ex_valid=0, ex_ctrl=NOP_CTRL, ex_pc=0 immediately. Release -> the first valid instruction appears one cycle later.
- Bypass: wb_we3=1, wb_a3=5, wb_wd=0xDEADBEEF, in_rs1=5, rf_d1=0x11 -> ex_rs1_val=0xDEADBEEF next cycle. With wb_a3=0, the same stimulus -> ex_rs1_val=0x11 (0 when in_rs1=0).
- Stall refresh: ex holds rs2=7, stall=1 for 3 cycles, write x7=0x1234 on cycle 2 -> ex_rs2_val=0x1234 after cycle 2, with all other fields unchanged.
- Load-use: ex holds lw x3, in_rs1=3 -> hazard_stall=1 for one cycle, bubble inserted (ex_valid=0). The dependent instruction enters on the following cycle.
- Flush priority: flush=1 and stall=1 together -> ex_valid=0, ex_ctrl=NOP_CTRL next cycle.
- Macro off: the bypass stimulus from scenario 2 -> ex_rs1_val=0x11.
